// File: rtl/fpu_pkg.sv
// Shared definitions for the parametrised floating-point adder/subtractor:
// FSM encodings, status bit positions and width helpers.
package fpu_pkg;

  localparam int FPU_DEF_EXP_W = 8;
  localparam int FPU_DEF_MAN_W = 23;
  localparam int FPU_MAX_W     = 128;

  typedef logic [2:0] fpu_state_t;

  localparam fpu_state_t ST_IDLE   = 3'd0;
  localparam fpu_state_t ST_UNPACK = 3'd1;
  localparam fpu_state_t ST_ALIGN  = 3'd2;
  localparam fpu_state_t ST_ADD    = 3'd3;
  localparam fpu_state_t ST_NORM   = 3'd4;
  localparam fpu_state_t ST_ROUND  = 3'd5;
  localparam fpu_state_t ST_DONE   = 3'd6;

  localparam int STAT_EXACT_IDX     = 0;
  localparam int STAT_OVERFLOW_IDX  = 1;
  localparam int STAT_UNDERFLOW_IDX = 2;
  localparam int STAT_INEXACT_IDX   = 3;

  localparam logic [3:0] STATUS_EXACT     = 4'(1 << STAT_EXACT_IDX);
  localparam logic [3:0] STATUS_OVERFLOW  = 4'(1 << STAT_OVERFLOW_IDX);
  localparam logic [3:0] STATUS_UNDERFLOW = 4'(1 << STAT_UNDERFLOW_IDX);
  localparam logic [3:0] STATUS_INEXACT   = 4'(1 << STAT_INEXACT_IDX);

  function automatic int fpu_word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // {carry, hidden, fraction, G, R, S}
  function automatic int fpu_sig_w(input int man_w);
    return man_w + 5;
  endfunction

  // Two spare bits keep over/underflow visible as a signed value.
  function automatic int fpu_exp_int_w(input int exp_w);
    return exp_w + 2;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [FPU_MAX_W-1:0] fpu_qnan(input int exp_w, input int man_w);
    logic [FPU_MAX_W-1:0] one;
    logic [FPU_MAX_W-1:0] r;
    one = FPU_MAX_W'(1);
    r   = ((one << exp_w) - one) << man_w;
    r   = r | (one << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports N.
module fpu_lzc #(
  parameter int N  = 27,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  data_in,
  output logic [CW-1:0] count_out
);

  // The last hit in an ascending scan is the most significant set bit.
  always_comb begin
    count_out = CW'(N);
    for (int i = 0; i < N; i++) begin
      if ((data_in >> i) != '0) begin
        count_out = CW'(N - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_param.sv
// Multi-cycle IEEE-754-style adder/subtractor with RNE rounding, special-value
// handling and valid/ready handshakes; one operation in flight at a time.
module fpu_addsub_param
  import fpu_pkg::*;
#(
  parameter  int EXP_W = FPU_DEF_EXP_W,
  parameter  int MAN_W = FPU_DEF_MAN_W,
  localparam int W     = fpu_word_w(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] Op_A_in,
  input  logic [W-1:0] Op_B_in,
  input  logic         op_select,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out,
  output logic         invalid_out
);

  localparam int SIG_W  = fpu_sig_w(MAN_W);
  localparam int EW     = fpu_exp_int_w(EXP_W);
  localparam int LZ_N   = SIG_W - 1;
  localparam int LZ_CW  = $clog2(LZ_N + 1);
  localparam int SH_MAX = MAN_W + 3;

  localparam logic [FPU_MAX_W-1:0] QNAN_FULL = fpu_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN      = QNAN_FULL[W-1:0];
  localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO  = '0;

  fpu_state_t state_q, state_d;

  logic [W-1:0]           a_q, a_d, b_q, b_d;
  logic                   op_q, op_d;
  logic                   sign_l_q, sign_l_d, sign_s_q, sign_s_d;
  logic [EXP_W-1:0]       exp_l_q, exp_l_d, exp_s_q, exp_s_d;
  logic [MAN_W:0]         man_l_q, man_l_d, man_s_q, man_s_d;
  logic                   nan_q, nan_d, inf_q, inf_d, inf_sign_q, inf_sign_d;
  logic [SIG_W-1:0]       sig_l_q, sig_l_d, sig_s_q, sig_s_d;
  logic [SIG_W-1:0]       sum_q, sum_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [SIG_W-2:0]       sig_n_q, sig_n_d;
  logic signed [EW-1:0]   exp_n_q, exp_n_d;
  logic                   zero_q, zero_d;
  logic                   out_valid_q, out_valid_d;
  logic [W-1:0]           data_q, data_d;
  logic [3:0]             status_q, status_d;
  logic                   invalid_q, invalid_d;

  // Combinational stage results, muxed into registers by the FSM.
  logic                   un_sa, un_sb, un_a_ge_b;
  logic [EXP_W-1:0]       un_ea, un_eb;
  logic [MAN_W:0]         un_ma, un_mb;
  logic                   un_nan_a, un_nan_b, un_inf_a, un_inf_b;
  logic [31:0]            al_diff, al_shamt;
  logic [MAN_W+3:0]       al_ext, al_shifted, al_lost_mask;
  logic [SIG_W-1:0]       al_sig_s;
  logic [SIG_W-1:0]       add_sum;
  logic [LZ_CW-1:0]       lz;
  logic                   rnd_g, rnd_r, rnd_s, rnd_lsb, rnd_inexact, rnd_inc;
  logic [MAN_W+1:0]       rnd_mant;
  logic signed [EW-1:0]   rnd_exp;
  logic [MAN_W-1:0]       rnd_frac;
  logic [W-1:0]           rnd_data;
  logic [3:0]             rnd_status;
  logic                   rnd_invalid;

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = out_valid_q;
  assign data_out    = data_q;
  assign status_out  = status_q;
  assign invalid_out = invalid_q;

  fpu_lzc #(
    .N (LZ_N)
  ) u_lzc (
    .data_in   (sum_q[SIG_W-2:0]),
    .count_out (lz)
  );

  // Unpack: zero-exponent inputs are flushed, operands ordered by magnitude.
  always_comb begin
    un_sa     = a_q[W-1];
    un_sb     = b_q[W-1] ^ op_q;
    un_ea     = a_q[W-2:MAN_W];
    un_eb     = b_q[W-2:MAN_W];
    un_ma     = (un_ea == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
    un_mb     = (un_eb == '0) ? '0 : {1'b1, b_q[MAN_W-1:0]};
    un_nan_a  = (&un_ea) & (|a_q[MAN_W-1:0]);
    un_nan_b  = (&un_eb) & (|b_q[MAN_W-1:0]);
    un_inf_a  = (&un_ea) & ~(|a_q[MAN_W-1:0]);
    un_inf_b  = (&un_eb) & ~(|b_q[MAN_W-1:0]);
    un_a_ge_b = {un_ea, un_ma} >= {un_eb, un_mb};
  end

  // Align: shifted-out bits collapse into S; the shift saturates once the
  // hidden bit has reached S.
  always_comb begin
    al_diff      = 32'(exp_l_q) - 32'(exp_s_q);
    al_shamt     = (al_diff > 32'(SH_MAX)) ? 32'(SH_MAX) : al_diff;
    al_ext       = {man_s_q, 3'b000};
    al_lost_mask = ~({(MAN_W+4){1'b1}} << al_shamt);
    al_shifted   = al_ext >> al_shamt;
    al_sig_s     = {1'b0, al_shifted[MAN_W+3:1], al_shifted[0] | (|(al_ext & al_lost_mask))};
    add_sum      = (sign_l_q ^ sign_s_q) ? (sig_l_q - sig_s_q) : (sig_l_q + sig_s_q);
  end

  // Round to nearest even, then resolve specials, zero and range limits.
  always_comb begin
    rnd_g       = sig_n_q[2];
    rnd_r       = sig_n_q[1];
    rnd_s       = sig_n_q[0];
    rnd_lsb     = sig_n_q[3];
    rnd_inexact = rnd_g | rnd_r | rnd_s;
    rnd_inc     = rnd_g & (rnd_r | rnd_s | rnd_lsb);
    rnd_mant    = {1'b0, sig_n_q[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
    rnd_exp     = rnd_mant[MAN_W+1] ? (exp_n_q + EXP_ONE) : exp_n_q;
    rnd_frac    = rnd_mant[MAN_W+1] ? rnd_mant[MAN_W:1] : rnd_mant[MAN_W-1:0];
    rnd_invalid = 1'b0;
    if (nan_q) begin
      rnd_data    = QNAN;
      rnd_status  = 4'b0000;
      rnd_invalid = 1'b1;
    end else if (inf_q) begin
      rnd_data   = {inf_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_status = STATUS_EXACT;
    end else if (zero_q) begin
      // Only (-0)+(-0) keeps a negative sign on an exact zero.
      rnd_data   = {sign_l_q & sign_s_q, {(W-1){1'b0}}};
      rnd_status = STATUS_EXACT;
    end else if (exp_n_q <= EXP_ZERO) begin
      rnd_data   = '0;
      rnd_status = STATUS_INEXACT | STATUS_UNDERFLOW;
    end else if (rnd_exp >= EXP_MAX) begin
      rnd_data   = {sign_l_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_status = STATUS_INEXACT | STATUS_OVERFLOW;
    end else begin
      rnd_data   = {sign_l_q, rnd_exp[EXP_W-1:0], rnd_frac};
      rnd_status = rnd_inexact ? STATUS_INEXACT : STATUS_EXACT;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    sign_l_d    = sign_l_q;
    sign_s_d    = sign_s_q;
    exp_l_d     = exp_l_q;
    exp_s_d     = exp_s_q;
    man_l_d     = man_l_q;
    man_s_d     = man_s_q;
    nan_d       = nan_q;
    inf_d       = inf_q;
    inf_sign_d  = inf_sign_q;
    sig_l_d     = sig_l_q;
    sig_s_d     = sig_s_q;
    sum_d       = sum_q;
    exp_d       = exp_q;
    sig_n_d     = sig_n_q;
    exp_n_d     = exp_n_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    status_d    = status_q;
    invalid_d   = invalid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = Op_A_in;
          b_d     = Op_B_in;
          op_d    = op_select;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        sign_l_d   = un_a_ge_b ? un_sa : un_sb;
        sign_s_d   = un_a_ge_b ? un_sb : un_sa;
        exp_l_d    = un_a_ge_b ? un_ea : un_eb;
        exp_s_d    = un_a_ge_b ? un_eb : un_ea;
        man_l_d    = un_a_ge_b ? un_ma : un_mb;
        man_s_d    = un_a_ge_b ? un_mb : un_ma;
        nan_d      = un_nan_a | un_nan_b | (un_inf_a & un_inf_b & (un_sa ^ un_sb));
        inf_d      = un_inf_a | un_inf_b;
        inf_sign_d = un_inf_a ? un_sa : un_sb;
        state_d    = ST_ALIGN;
      end
      ST_ALIGN: begin
        sig_l_d = {1'b0, man_l_q, 3'b000};
        sig_s_d = al_sig_s;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        sum_d   = add_sum;
        exp_d   = $signed({2'b00, exp_l_q});
        state_d = ST_NORM;
      end
      ST_NORM: begin
        zero_d = 1'b0;
        if (sum_q[SIG_W-1]) begin
          sig_n_d = {sum_q[SIG_W-1:2], |sum_q[1:0]};
          exp_n_d = exp_q + EXP_ONE;
        end else if (sum_q == '0) begin
          sig_n_d = '0;
          exp_n_d = exp_q;
          zero_d  = 1'b1;
        end else begin
          sig_n_d = sum_q[SIG_W-2:0] << lz;
          exp_n_d = exp_q - $signed(EW'(lz));
        end
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        data_d      = rnd_data;
        status_d    = rnd_status;
        invalid_d   = rnd_invalid;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      status_q    <= '0;
      invalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      status_q    <= status_d;
      invalid_q   <= invalid_d;
    end
  end

  // Datapath registers are only consumed in the state after they load.
  always_ff @(posedge clk) begin
    a_q        <= a_d;
    b_q        <= b_d;
    op_q       <= op_d;
    sign_l_q   <= sign_l_d;
    sign_s_q   <= sign_s_d;
    exp_l_q    <= exp_l_d;
    exp_s_q    <= exp_s_d;
    man_l_q    <= man_l_d;
    man_s_q    <= man_s_d;
    nan_q      <= nan_d;
    inf_q      <= inf_d;
    inf_sign_q <= inf_sign_d;
    sig_l_q    <= sig_l_d;
    sig_s_q    <= sig_s_d;
    sum_q      <= sum_d;
    exp_q      <= exp_d;
    sig_n_q    <= sig_n_d;
    exp_n_q    <= exp_n_d;
    zero_q     <= zero_d;
  end

endmodule
